fir_tap_accumulator: RTL and testbench
======================================

// Module: fir_tap_accumulator
// PURPOSE
//   Downstream stage of the FIR cascade tap multiplier (16s x 15u -> 31s product).
//   Consumes one signed product per tap and accumulates NUM_TAPS products per output
//   sample. Rounds, scales and saturates the sum to OUT_WIDTH, then presents it on a
//   valid/ready output port. Feeds the next decimator/filter stage of the cascade.
// PARAMETERS
//   PROD_WIDTH  31  signed product width from the multiplier
//   ACC_WIDTH   40  accumulator width; must be >= PROD_WIDTH + clog2(NUM_TAPS)
//   OUT_WIDTH   16  signed output sample width
//   NUM_TAPS    32  products per output sample; must be >= 2
//   FRAC_SHIFT  15  right shift applied to the sum (coefficient Q-format); must be >= 1
// PORTS
//   ap_clk      in   1           clock, rising edge
//   ap_rst_n    in   1           asynchronous reset, active low
//   acc_clr     in   1           synchronous frame restart; discards the partial sum
//   prod_tdata  in   PROD_WIDTH  signed tap product
//   prod_tvalid in   1           product valid
//   prod_tready out  1           product accepted when valid && ready
//   out_tdata   out  OUT_WIDTH   signed filtered sample
//   out_tvalid  out  1           output sample valid
//   out_tready  in   1           downstream ready
//   sat_flag    out  1           sticky flag: saturation occurred
// BEHAVIOUR
//   - Reset (async, ap_rst_n=0): tap_cnt=0, acc=0, out_tdata=0, out_tvalid=0, sat_flag=0.
//   - prod_tready = !out_tvalid || out_tready (combinational). Stalls only while an
//     output sample is held unconsumed.
//   - Product is sign-extended to ACC_WIDTH.
//   - On each accepted beat:
//       - tap_cnt==0: acc <= sext(prod).
//       - Otherwise: acc <= acc + sext(prod).
//       - tap_cnt increments, wrapping to 0 after NUM_TAPS-1.
//   - On an accepted beat with tap_cnt==NUM_TAPS-1:
//       - sum = acc + sext(prod).
//       - r = (sum + 2**(FRAC_SHIFT-1)) >>> FRAC_SHIFT (round half up, arithmetic shift).
//       - out_tdata <= fit(r); out_tvalid <= 1 on the next edge.
//       - Latency: 1 cycle from the last-product handshake.
//   - out_tvalid clears on out_tvalid && out_tready unless a new sample loads in the
//     same cycle; in that case the new sample replaces it and valid stays 1.
//   - out_tdata is stable while out_tvalid && !out_tready.
//   - acc_clr=1: tap_cnt <= 0. If a beat is accepted in the same cycle, that beat is
//     tap 0 (acc <= sext(prod), tap_cnt <= 1). No output is produced from a
//     cleared frame. A pending out_tvalid/out_tdata is unaffected.
//   - Reset mid-frame: partial sum and any pending output are lost.
//   - prod_tvalid low: no state change; gaps between beats are allowed.
// CONFIGURATION
//   SAT_EN defined:
//     - fit(r) clamps to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1].
//     - sat_flag is set on any clamp and cleared only by reset.
//   SAT_EN undefined:
//     - fit(r) = r[OUT_WIDTH-1:0] (two's-complement wrap).
//     - sat_flag is tied to 0.
// TESTING  (NUM_TAPS=4, FRAC_SHIFT=15, OUT_WIDTH=16)
//   - 4 beats of 32768, out_tready=1 -> out_tdata=4, out_tvalid one cycle after 4th beat.
//   - Products {16384,0,0,0} -> 1; products {-16385,0,0,0} -> -1 (rounding check).
//   - 4 beats of 2**30-1 -> SAT_EN: 32767 and sat_flag=1; no SAT_EN: 0 and sat_flag=0.
//   - out_tready=0 for 10 cycles after a sample -> prod_tready=0, out_tdata held;
//     release -> next frame accumulates correctly with no beat lost or duplicated.
//   - 2 beats of 1000, acc_clr with 3rd beat, then 3 more beats of 32768 -> output 4.
//   - ap_rst_n pulsed low after 2 beats -> all outputs 0 asynchronously; next 4 beats
//     of 32768 -> output 4.

Source files
------------

// File: rtl/fir_tap_accumulator.sv
// fir_tap_accumulator
//   Accumulates NUM_TAPS signed tap products per output sample, then rounds
//   (half up), shifts right by FRAC_SHIFT and fits the result to OUT_WIDTH.
//   The sample is held on a valid/ready output port; product intake stalls
//   only while an output sample is waiting to be consumed.
//   Build option: define SAT_EN to clamp the output and raise the sticky
//   sat_flag; without it the output wraps and sat_flag is tied low.
module fir_tap_accumulator #(
  parameter int PROD_WIDTH = 31,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_TAPS   = 32,
  parameter int FRAC_SHIFT = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  acc_clr,
  input  logic [PROD_WIDTH-1:0] prod_tdata,
  input  logic                  prod_tvalid,
  output logic                  prod_tready,
  output logic [OUT_WIDTH-1:0]  out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  sat_flag
);

  localparam int CNT_W = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);
  // Rounding constant 2**(FRAC_SHIFT-1), one bit wider than the accumulator
  localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);

`ifdef SAT_EN
  localparam logic signed [ACC_WIDTH:0] OUT_MAX =
    {{(ACC_WIDTH + 1 - OUT_WIDTH){1'b0}}, 1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] OUT_MIN =
    {{(ACC_WIDTH + 1 - OUT_WIDTH){1'b1}}, 1'b1, {(OUT_WIDTH - 1){1'b0}}};
`endif

  logic [CNT_W-1:0]            tap_cnt;
  logic signed [ACC_WIDTH-1:0] acc_p0;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH:0]   rnd;
  logic                        accept;
  logic                        first_tap;
  logic                        last_tap;
  logic                        load;

  // Round half up and arithmetic shift; the extra bit keeps the +HALF from overflowing
  function automatic logic signed [ACC_WIDTH:0] round_shift(input logic signed [ACC_WIDTH-1:0] s);
    logic signed [ACC_WIDTH:0] w;
    w = {s[ACC_WIDTH-1], s};
    w = w + HALF;
    return w >>> FRAC_SHIFT;
  endfunction

`ifdef SAT_EN
  function automatic logic clamps(input logic signed [ACC_WIDTH:0] r);
    return (r > OUT_MAX) || (r < OUT_MIN);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] fit(input logic signed [ACC_WIDTH:0] r);
    if (r > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
    if (r < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    return r[OUT_WIDTH-1:0];
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] fit(input logic signed [ACC_WIDTH:0] r);
    return r[OUT_WIDTH-1:0];
  endfunction
`endif

  assign prod_tready = !out_tvalid || out_tready;
  assign accept      = prod_tvalid && prod_tready;
  // A clear in the same cycle as a beat makes that beat tap 0 of a fresh frame
  assign first_tap   = acc_clr || (tap_cnt == '0);
  assign last_tap    = !acc_clr && (tap_cnt == LAST_TAP);
  assign load        = accept && last_tap;

  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){prod_tdata[PROD_WIDTH-1]}}, prod_tdata};
  assign sum      = first_tap ? prod_ext : acc_p0 + prod_ext;
  assign rnd      = round_shift(sum);

  // Tap counter: restarts on clear, wraps after the last tap of a frame
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      tap_cnt <= '0;
    end else if (accept) begin
      if (last_tap) tap_cnt <= '0;
      else if (first_tap) tap_cnt <= CNT_W'(1);
      else tap_cnt <= tap_cnt + CNT_W'(1);
    end else if (acc_clr) begin
      tap_cnt <= '0;
    end
  end

  // Running sum of the current frame
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) acc_p0 <= '0;
    else if (accept) acc_p0 <= sum;
  end

  // Output holding register: loads on the last tap, drops valid once consumed
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
    end else if (load) begin
      out_tdata  <= fit(rnd);
      out_tvalid <= 1'b1;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

`ifdef SAT_EN
  // Sticky saturation indicator, cleared only by reset
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) sat_flag <= 1'b0;
    else if (load && clamps(rnd)) sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Testbench for fir_tap_accumulator (NUM_TAPS=4, FRAC_SHIFT=15, OUT_WIDTH=16).
// Follows the SAT_EN define of the build for its expected values.
module tb_fir_tap_accumulator;

  localparam int PW = 31;
  localparam int AW = 40;
  localparam int OW = 16;
  localparam int NT = 4;
  localparam int FS = 15;

`ifdef SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          acc_clr;
  logic [PW-1:0] prod_tdata;
  logic          prod_tvalid;
  logic          prod_tready;
  logic [OW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready;
  logic          sat_flag;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int p [4];
    int exp_out;
    int exp_sat;
  } vec_t;

  vec_t vecs[$];

  always #5 ap_clk = ~ap_clk;

  fir_tap_accumulator #(
    .PROD_WIDTH(PW),
    .ACC_WIDTH (AW),
    .OUT_WIDTH (OW),
    .NUM_TAPS  (NT),
    .FRAC_SHIFT(FS)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .acc_clr    (acc_clr),
    .prod_tdata (prod_tdata),
    .prod_tvalid(prod_tvalid),
    .prod_tready(prod_tready),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .sat_flag   (sat_flag)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  // Offer one beat and hold it until the handshake edge has passed
  task automatic send_beat(input int p, input bit clr);
    int n;
    n = 0;
    prod_tdata  = PW'(p);
    prod_tvalid = 1'b1;
    acc_clr     = clr;
    while (!prod_tready && n < 50) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (n >= 50) chk("beat_accept_timeout", {31'b0, prod_tready}, 1);
    @(posedge ap_clk);
    #1;
    prod_tvalid = 1'b0;
    acc_clr     = 1'b0;
  endtask

  task automatic add_vec(input int a, input int b, input int c, input int d,
                         input int eo, input int es);
    vec_t v;
    v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.exp_out = eo;
    v.exp_sat = es;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst_n    = 1'b0;
    acc_clr     = 1'b0;
    prod_tvalid = 1'b0;
    prod_tdata  = '0;
    out_tready  = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("reset_out_tvalid",  {31'b0, out_tvalid}, 0);
    chk("reset_out_tdata",   $signed(out_tdata), 0);
    chk("reset_sat_flag",    {31'b0, sat_flag}, 0);
    chk("reset_prod_tready", {31'b0, prod_tready}, 1);
    ap_rst_n = 1'b1;
    idle(1);

    // Products and expected outputs; the clamping frames come last since sat_flag is sticky
    add_vec(32768, 32768, 32768, 32768, 4, 0);
    add_vec(16384, 0, 0, 0, 1, 0);
    add_vec(-16385, 0, 0, 0, -1, 0);
    add_vec(-16384, 0, 0, 0, 0, 0);
    add_vec(100000, -50000, 200000, -7, 8, 0);
    add_vec(-98304, 0, 0, -1, -3, 0);
    add_vec(1073709056, 0, 0, 0, 32767, 0);
    add_vec(-1073741824, 0, 0, 0, -32768, 0);
    add_vec(1073725440, 0, 0, 0, SAT ? 32767 : -32768, SAT ? 1 : 0);
    add_vec(1073741823, 1073741823, 1073741823, 1073741823, SAT ? 32767 : 0, SAT ? 1 : 0);
    add_vec(-1073741824, -1073741824, -1073741824, -1073741824, SAT ? -32768 : 0, SAT ? 1 : 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < NT; k++) begin
        idle(i % 3);
        if (k == NT - 1) chk($sformatf("vec%0d_valid_early", i), {31'b0, out_tvalid}, 0);
        send_beat(vecs[i].p[k], 1'b0);
      end
      chk($sformatf("vec%0d_valid", i), {31'b0, out_tvalid}, 1);
      chk($sformatf("vec%0d_data", i), $signed(out_tdata), vecs[i].exp_out);
      chk($sformatf("vec%0d_sat", i), {31'b0, sat_flag}, vecs[i].exp_sat);
      idle(1);
      chk($sformatf("vec%0d_valid_clear", i), {31'b0, out_tvalid}, 0);
    end

    // Back-pressure: sample held for 10 cycles, the offered beat must wait
    out_tready = 1'b0;
    for (int k = 0; k < NT; k++) send_beat(32768, 1'b0);
    chk("stall_valid", {31'b0, out_tvalid}, 1);
    chk("stall_data", $signed(out_tdata), 4);
    prod_tdata  = PW'(32768);
    prod_tvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      idle(1);
      chk($sformatf("stall%0d_ready", c), {31'b0, prod_tready}, 0);
      chk($sformatf("stall%0d_data", c), $signed(out_tdata), 4);
      chk($sformatf("stall%0d_valid", c), {31'b0, out_tvalid}, 1);
    end
    out_tready = 1'b1;
    idle(1);
    prod_tvalid = 1'b0;
    chk("release_valid_clear", {31'b0, out_tvalid}, 0);
    send_beat(32768, 1'b0);
    send_beat(0, 1'b0);
    chk("release_valid_early", {31'b0, out_tvalid}, 0);
    send_beat(0, 1'b0);
    chk("release_valid", {31'b0, out_tvalid}, 1);
    chk("release_data", $signed(out_tdata), 2);
    idle(1);

    // Clear together with a beat: that beat starts the new frame
    send_beat(1000, 1'b0);
    send_beat(1000, 1'b0);
    send_beat(32768, 1'b1);
    chk("clrbeat_valid_a", {31'b0, out_tvalid}, 0);
    send_beat(32768, 1'b0);
    chk("clrbeat_valid_b", {31'b0, out_tvalid}, 0);
    send_beat(32768, 1'b0);
    chk("clrbeat_valid_c", {31'b0, out_tvalid}, 0);
    send_beat(32768, 1'b0);
    chk("clrbeat_valid", {31'b0, out_tvalid}, 1);
    chk("clrbeat_data", $signed(out_tdata), 4);
    idle(1);

    // Clear with no beat in the same cycle
    send_beat(32768, 1'b0);
    send_beat(32768, 1'b0);
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    send_beat(16384, 1'b0);
    send_beat(16384, 1'b0);
    chk("clridle_valid_early", {31'b0, out_tvalid}, 0);
    send_beat(16384, 1'b0);
    send_beat(16384, 1'b0);
    chk("clridle_valid", {31'b0, out_tvalid}, 1);
    chk("clridle_data", $signed(out_tdata), 2);
    idle(1);

    // Asynchronous reset mid-frame, asserted between clock edges
    send_beat(32768, 1'b0);
    send_beat(32768, 1'b0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_out_tdata",  $signed(out_tdata), 0);
    chk("arst_out_tvalid", {31'b0, out_tvalid}, 0);
    chk("arst_sat_flag",   {31'b0, sat_flag}, 0);
    chk("arst_prod_tready", {31'b0, prod_tready}, 1);
    idle(2);
    ap_rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < NT - 1; k++) send_beat(32768, 1'b0);
    chk("arst_valid_early", {31'b0, out_tvalid}, 0);
    send_beat(32768, 1'b0);
    chk("arst_valid", {31'b0, out_tvalid}, 1);
    chk("arst_data", $signed(out_tdata), 4);
    chk("arst_sat_after", {31'b0, sat_flag}, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
